// File: rtl/switch_egress_arbiter.sv
// Egress-port scheduler: target-filtered, packet-locked round-robin over four ingress ports.
// Optional per-requester grant counters when SWITCH_ARB_STATS_EN is defined.
module switch_egress_arbiter #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 2,
    parameter int PORT_ID = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          req_valid,
    input  logic [4*ADDR_W-1:0] req_source,
    input  logic [4*ADDR_W-1:0] req_target,
    input  logic [4*DATA_W-1:0] req_data,
    input  logic [3:0]          req_last,
    output logic [3:0]          req_ready,
    output logic                out_valid,
    output logic [ADDR_W-1:0]   out_source,
    output logic [ADDR_W-1:0]   out_target,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_last,
    input  logic                out_ready,
    output logic                lock_valid,
`ifdef SWITCH_ARB_STATS_EN
    input  logic                stats_clr,
    output logic [63:0]         grant_cnt,
`endif
    output logic [1:0]          lock_owner
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t     state, state_d;
    logic [1:0] rr_ptr, rr_ptr_d;
    logic [1:0] owner, owner_d;
    logic [3:0] hit;
    logic       load_en;
    logic       accept;
    logic [1:0] win;
    logic [1:0] sel;
    logic       sel_found;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            hit[i] = req_valid[i] && (req_target[i*ADDR_W +: ADDR_W] == ADDR_W'(PORT_ID));
        end
    end

    assign load_en = !out_valid || out_ready;

    // Rotating priority search starting at rr_ptr.
    always_comb begin
        logic [1:0] idx;
        sel       = rr_ptr;
        sel_found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = rr_ptr + 2'(k);
            if (!sel_found && hit[idx]) begin
                sel       = idx;
                sel_found = 1'b1;
            end
        end
    end

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state;
        rr_ptr_d  = rr_ptr;
        owner_d   = owner;
        req_ready = 4'b0000;
        accept    = 1'b0;
        win       = sel;
        case (state)
            IDLE: begin
                if (sel_found && load_en) begin
                    req_ready[sel] = 1'b1;
                    accept         = 1'b1;
                    if (req_last[sel]) begin
                        rr_ptr_d = sel + 2'd1;
                    end else begin
                        state_d = BUSY;
                        owner_d = sel;
                    end
                end
            end
            BUSY: begin
                // Owner bubbles stall the port; nobody else may cut in mid-packet.
                win = owner;
                if (hit[owner] && load_en) begin
                    req_ready[owner] = 1'b1;
                    accept           = 1'b1;
                    if (req_last[owner]) begin
                        state_d  = IDLE;
                        rr_ptr_d = owner + 2'd1;
                        owner_d  = 2'd0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= 2'd0;
            owner  <= 2'd0;
        end else begin
            state  <= state_d;
            rr_ptr <= rr_ptr_d;
            owner  <= owner_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_source <= '0;
            out_target <= '0;
            out_data   <= '0;
            out_last   <= 1'b0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_source <= req_source[win*ADDR_W +: ADDR_W];
            out_target <= req_target[win*ADDR_W +: ADDR_W];
            out_data   <= req_data[win*DATA_W +: DATA_W];
            out_last   <= req_last[win];
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    assign lock_valid = (state == BUSY);
    assign lock_owner = owner;

`ifdef SWITCH_ARB_STATS_EN
    logic [15:0] cnt [4];

    // Clear takes priority over a same-cycle packet completion.
    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            for (int i = 0; i < 4; i++) cnt[i] <= 16'd0;
        end else if (accept && req_last[win] && (cnt[win] != 16'hFFFF)) begin
            cnt[win] <= cnt[win] + 16'd1;
        end
    end

    assign grant_cnt = {cnt[3], cnt[2], cnt[1], cnt[0]};
`endif

endmodule

// File: doc/switch_egress_arbiter.md
Name: switch_egress_arbiter

Overview:
- Per-egress-port scheduler for the 4-port switch: shares one output port among the four ingress ports that target it.
- Filters requests by target address and arbitrates round-robin at packet granularity: once a requester is granted, the grant locks until that requester's last beat.
- Registers the winning beat into a single valid/ready output stage.
- One instance sits in front of each port's output side of switch_4port.

Parameters:
- DATA_W, 8, payload width per beat
- ADDR_W, 2, width of source/target port IDs
- PORT_ID, 0, egress port this instance serves; compared against req_target

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  4  per-ingress beat valid
- req_source  in  4*ADDR_W  per-ingress source ID; slice i = [i*ADDR_W +: ADDR_W]
- req_target  in  4*ADDR_W  per-ingress target ID
- req_data  in  4*DATA_W  per-ingress payload
- req_last  in  4  per-ingress end-of-packet flag
- req_ready  out  4  per-ingress accept; combinational
- out_valid  out  1  registered egress valid
- out_source  out  ADDR_W  registered source ID
- out_target  out  ADDR_W  registered target ID; always equals PORT_ID when out_valid=1
- out_data  out  DATA_W  registered payload
- out_last  out  1  registered end-of-packet
- out_ready  in  1  egress backpressure
- lock_valid  out  1  1 while a multi-beat packet holds the grant (state BUSY)
- lock_owner  out  2  index of the current owner; 0 when idle

Behaviour:
- Request filter: hit[i] = req_valid[i] && (req_target slice i == PORT_ID).
- Load enable: load_en = !out_valid || out_ready.
- A beat transfers on an ingress when req_valid[i] && req_ready[i].
- A beat transfers on egress when out_valid && out_ready.
- req_ready[i] is 1 only for the selected requester, and only when load_en=1. It never depends on req_ready of any other input.
- State machine: IDLE and BUSY. Registers: rr_ptr (2b), owner (2b).
- IDLE:
  - Selection: the first i with hit[i], searching i = rr_ptr, rr_ptr+1, ... mod 4.
  - If load_en=1 and any hit: accept that beat and load the output register.
  - If the beat has last=1: stay IDLE and set rr_ptr = g+1 mod 4.
  - Otherwise: go to BUSY with owner=g; rr_ptr is unchanged.
- BUSY:
  - Only the owner is served, and only when hit[owner] && load_en.
  - If the owner deasserts valid, no beat loads (a bubble) and no other requester is granted.
  - When the owner's last beat is accepted: go to IDLE and set rr_ptr = owner+1 mod 4.
- Output register:
  - If load_en && accept: capture source/target/data/last from the winner and set out_valid=1.
  - Else if out_ready: out_valid=0.
  - Else: hold all fields stable.
- Latency: 1 cycle from ingress acceptance to out_valid.
- Throughput: 1 beat/cycle with out_ready held at 1.
- Simultaneous events: egress drain and ingress load in the same cycle are legal (load_en=1 via out_ready).
- Non-hit requesters always see req_ready=0.
- Reset (any cycle, including mid-packet): state=IDLE, rr_ptr=0, owner=0, out_valid=0, out_source=0, out_target=0, out_data=0, out_last=0, lock_valid=0, lock_owner=0. The partial packet is dropped and no further beat of it is accepted until the next arbitration.
- rr_ptr wraps 3 -> 0.

Optional Feature:
- Macro: SWITCH_ARB_STATS_EN.
- Defined:
  - Adds four 16-bit grant counters, one per requester. A counter increments when its requester's last beat is accepted, saturates at 16'hFFFF, and clears on rst.
  - Adds output port grant_cnt (64 bits, slice i = [i*16 +: 16]).
  - Adds input port stats_clr (1 bit), which synchronously zeroes all counters. If a last beat is accepted in the same cycle, stats_clr wins.
- Undefined: neither port exists; no counters are built; all other behaviour is identical.

Test Plan:
- Single requester: rst released; req 2 sends 1 beat with target=PORT_ID=0, data=8'hA5, last=1, out_ready=1 -> req_ready[2]=1 in the same cycle; next cycle out_valid=1, out_source=2, out_data=A5, out_last=1; rr_ptr becomes 3.
- Round-robin fairness: all 4 requesters send continuous single-beat packets to PORT_ID, out_ready=1 -> grant order 0,1,2,3,0,... with one beat per cycle and no bubbles.
- Packet lock: req 1 sends 3 beats (last on the 3rd) while req 0 and req 3 also request -> three consecutive outputs all from source 1 with lock_valid=1 and lock_owner=1 during beats 1-2; then req 3 (not req 0) wins the next grant.
- Target filter: req 0 has target=1 with PORT_ID=0 -> req_ready[0] stays 0 and out_valid stays 0 for 10 cycles.
- Backpressure: out_ready=0 for 5 cycles with out_valid=1 -> all out_* fields stable and req_ready=4'b0000; then out_ready=1 -> the held beat drains and a new beat loads in the same cycle.
- Reset mid-packet: rst asserted after beat 2 of a 4-beat packet -> next cycle out_valid=0, lock_valid=0, rr_ptr=0; with SWITCH_ARB_STATS_EN defined, grant_cnt=0.
